param_arbiter: RTL and testbench
================================

PARAM_ARBITER -- requirements
Module: param_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter LFSR_W, default 8, giving the random-mode LFSR width (legal range 4..16).
REQ-003 Derived width IDX_W = max(1, clog2(N_REQ)) SHALL be used for every index port.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_REQ  request vector; bit i is requester i.
REQ-007 arb_type  input  3  scheme select: 000 fixed-low, 001 fixed-programmable, 010 round-robin, 011 random; 1xx disabled.
REQ-008 prio_sel  input  IDX_W  top-priority index for mode 001.
REQ-009 lock_en  input  1  enables grant lock, i.e. the current grant is held while its request stays high.
REQ-010 gnt  output  N_REQ  registered one-hot grant, or all zeros.
REQ-011 gnt_id  output  IDX_W  index of the granted requester; 0 when gnt is zero.
REQ-012 gnt_valid  output  1  equals OR of gnt.

Function
REQ-013 gnt, gnt_id and gnt_valid SHALL be registered; they reflect the req and control inputs sampled on the previous rising edge, giving one-cycle latency.
REQ-014 gnt SHALL never have more than one bit set, and a set bit SHALL correspond to a request sampled high.
REQ-015 If req is all zeros, or arb_type is 1xx, the next gnt SHALL be all zeros.
REQ-016 Mode 000 SHALL grant the lowest-index asserted request.
REQ-017 Mode 001 SHALL grant prio_sel if it is asserted; otherwise it SHALL grant the lowest-index asserted request.
REQ-018 In mode 001, a prio_sel value of N_REQ or higher SHALL behave as mode 000.
REQ-019 Mode 010 SHALL search upward from last_id+1, wrapping modulo N_REQ, and grant the first asserted request.
REQ-020 last_id SHALL update to the granted index on every cycle that gnt_valid is set, in any mode.
REQ-021 last_id SHALL hold its value on cycles with no grant.
REQ-022 Mode 011 SHALL compute start = LFSR[IDX_W-1:0], reducing it by N_REQ when it is N_REQ or higher.
REQ-023 Mode 011 SHALL then search upward from start with wrap and grant the first asserted request.
REQ-024 The LFSR SHALL be a maximal-length Fibonacci LFSR that advances every cycle regardless of mode, and it SHALL never reach the all-zero state.
REQ-025 The lock SHALL override the scheme selected by arb_type: if lock_en=1, gnt_valid=1 and req[gnt_id]=1, the grant SHALL be held unchanged.
REQ-026 A locked grant SHALL be released on the cycle after its request drops, or after lock_en drops, and arbitration SHALL then resume normally.
REQ-027 The lock SHALL hold a grant for at most N_REQ*4 consecutive cycles. When that limit is reached the block SHALL force one arbitration that excludes the holder, unless the holder is the only requester.
REQ-028 A change of arb_type SHALL take effect on the next edge without any flush, and last_id SHALL be retained across the change.

Reset
REQ-029 On rst_n low, gnt SHALL be 0, gnt_id 0, gnt_valid 0, last_id N_REQ-1 (so that requester 0 is first in round-robin), the LFSR SHALL be loaded with the package seed, and the lock counter SHALL be 0.
REQ-030 Reset assertion SHALL take effect immediately, mid-lock or mid-grant.
REQ-031 After reset deasserts, the first grant SHALL appear one edge after a request is sampled.

Structure
REQ-032 A shared package arb_pkg SHALL hold the arb_type encoding constants, the LFSR taps table indexed by LFSR_W, and the LFSR seed (nonzero).
REQ-033 The LFSR SHALL be a separate sub-module, arb_lfsr, with parameter LFSR_W and ports clk, rst_n and value.
REQ-034 All search logic SHALL be one parametrised rotate-and-priority-encode function, reused by modes 001, 010 and 011.

Verification (N_REQ=4)
REQ-035 Mode 000 with req=1010: on the next edge gnt SHALL be 0010 and gnt_id 1; with req=0000, gnt SHALL be 0000 and gnt_valid 0.
REQ-036 Mode 010 with req=1111 held for 5 cycles after reset: gnt SHALL be 0001, 0010, 0100, 1000, 0001.
REQ-037 Mode 001 with prio_sel=2 and req=0101: gnt SHALL be 0100; then with req=0001, gnt SHALL be 0001.
REQ-038 Mode 010 with lock_en=1, req=0011: gnt 0001 SHALL be held while req[0]=1, and the cycle after req[0] drops, gnt SHALL be 0010. The same setup with req[0] never dropping SHALL force gnt 0010 after 16 cycles.
REQ-039 Mode 011 with req=1111 for 1000 cycles: gnt SHALL always be one-hot, every requester SHALL be granted at least 150 times, and the grant sequence SHALL repeat identically after reset.
REQ-040 Assert rst_n low mid-lock with gnt=1000: gnt SHALL become 0000 asynchronously, and the first round-robin grant with req=1001 after release SHALL be 0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for param_arbiter: scheme encodings, LFSR taps and seed.
package arb_pkg;

    typedef enum logic [2:0] {
        ARB_FIXED_LOW   = 3'b000,
        ARB_FIXED_PROG  = 3'b001,
        ARB_ROUND_ROBIN = 3'b010,
        ARB_RANDOM      = 3'b011
    } arb_type_e;

    // Fibonacci feedback masks (bit k-1 set for tap k), maximal length per width.
    localparam logic [15:0] LFSR_TAPS [4:16] = '{
        16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
        16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
    };

    // Bit 0 is set, so the seed stays nonzero when truncated to any width.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/arb_lfsr.sv
// Free-running maximal-length Fibonacci LFSR; never enters the all-zero state.
module arb_lfsr
    import arb_pkg::*;
#(
    parameter int unsigned LFSR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] value
);

    localparam logic [15:0]       TAPS_FULL = LFSR_TAPS[LFSR_W];
    localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED[LFSR_W-1:0];
        end else begin
            value <= {value[LFSR_W-2:0], ^(value & TAPS)};
        end
    end

endmodule

// File: rtl/param_arbiter.sv
// N_REQ-way arbiter: fixed, programmable-priority, round-robin and random
// schemes, with a bounded grant lock and registered one-hot grant.
module param_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned LFSR_W = 8,
    localparam int unsigned IDX_W  = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       arb_type,
    input  logic [IDX_W-1:0] prio_sel,
    input  logic             lock_en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid
);

    localparam int unsigned LOCK_MAX = N_REQ * 4;
    localparam int unsigned CNT_W    = $clog2(LOCK_MAX + 1);

    logic [LFSR_W-1:0] lfsr_val;
    logic              unused_lfsr_bits;
    logic [IDX_W-1:0]  last_id;
    logic [CNT_W-1:0]  hold_cnt;

    logic              lock_hit, at_limit, prio_hit, disabled, found;
    logic [N_REQ-1:0]  arb_req;
    logic [IDX_W:0]    rnd_ext, search;
    logic [IDX_W-1:0]  start, found_id;
    logic              nxt_valid;
    logic [IDX_W-1:0]  nxt_id;
    logic [CNT_W-1:0]  nxt_cnt;

    arb_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_val)
    );

    assign unused_lfsr_bits = ^lfsr_val;

    // Returns {found, index}: first set bit of vec at or above start, wrapping.
    function automatic logic [IDX_W:0] rr_search(input logic [N_REQ-1:0] vec,
                                                 input logic [IDX_W-1:0] from);
        logic [N_REQ-1:0] rot;
        logic [IDX_W-1:0] pos;
        logic [IDX_W:0]   sum;
        logic             hit;
        rot = N_REQ'({vec, vec} >> from);
        pos = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                pos = IDX_W'(i);
            end
        end
        sum = {1'b0, from} + {1'b0, pos};
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        return {hit, sum[IDX_W-1:0]};
    endfunction

    always_comb begin
        lock_hit = lock_en && |(req & gnt);
        at_limit = (hold_cnt == CNT_W'(LOCK_MAX));
        // At the lock limit the holder is masked out for one arbitration.
        arb_req  = (lock_hit && at_limit) ? (req & ~gnt) : req;
        prio_hit = |(arb_req & (N_REQ'(1) << prio_sel));
        rnd_ext  = {1'b0, lfsr_val[IDX_W-1:0]};
        if (rnd_ext >= (IDX_W+1)'(N_REQ)) rnd_ext = rnd_ext - (IDX_W+1)'(N_REQ);

        disabled = 1'b0;
        start    = '0;
        case (arb_type)
            ARB_FIXED_LOW:   start = '0;
            ARB_FIXED_PROG:  start = prio_hit ? prio_sel : '0;
            ARB_ROUND_ROBIN: start = (last_id == IDX_W'(N_REQ-1)) ? '0 : last_id + IDX_W'(1);
            ARB_RANDOM:      start = rnd_ext[IDX_W-1:0];
            default:         disabled = 1'b1;
        endcase

        search   = rr_search(arb_req, start);
        found    = search[IDX_W];
        found_id = search[IDX_W-1:0];

        nxt_valid = 1'b0;
        nxt_id    = '0;
        nxt_cnt   = '0;
        if (disabled) begin
            nxt_valid = 1'b0;
        end else if (lock_hit && !at_limit) begin
            nxt_valid = 1'b1;
            nxt_id    = gnt_id;
            nxt_cnt   = hold_cnt + CNT_W'(1);
        end else if (found) begin
            nxt_valid = 1'b1;
            nxt_id    = found_id;
            nxt_cnt   = CNT_W'(1);
        end else if (lock_hit) begin
            nxt_valid = 1'b1;
            nxt_id    = gnt_id;
            nxt_cnt   = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            last_id   <= IDX_W'(N_REQ-1);
            hold_cnt  <= '0;
        end else begin
            gnt       <= nxt_valid ? (N_REQ'(1) << nxt_id) : '0;
            gnt_id    <= nxt_id;
            gnt_valid <= nxt_valid;
            hold_cnt  <= nxt_cnt;
            if (nxt_valid) last_id <= nxt_id;
        end
    end

endmodule

// File: tb/tb_param_arbiter.sv
// Self-checking bench for param_arbiter: directed cases plus randomized run
// against a behavioural model of the arbitration rules.
module tb_param_arbiter;
    import arb_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned LIMIT = 4 * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [2:0] arb_type = '0;
    logic [1:0] prio_sel = '0;
    logic       lock_en = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    logic [5:0] req6 = '0;
    logic [2:0] prio6 = '0;
    logic [5:0] gnt6;
    logic [2:0] gid6;
    logic       gv6;

    int tests = 0;
    int fails = 0;

    int       m_id, m_last, m_run;
    bit       m_valid;
    bit [7:0] m_lfsr;

    logic [3:0] seq [1000];
    int         cnt [4];

    always #5 clk = ~clk;

    param_arbiter #(.N_REQ(4), .LFSR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .arb_type(arb_type),
        .prio_sel(prio_sel), .lock_en(lock_en),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
    );

    param_arbiter #(.N_REQ(6), .LFSR_W(5)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .arb_type(3'b001),
        .prio_sel(prio6), .lock_en(1'b0),
        .gnt(gnt6), .gnt_id(gid6), .gnt_valid(gv6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [3:0] v, input int from);
        for (int k = 0; k < N; k++)
            if (v[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        bit         locked;
        logic [3:0] cand;
        int         pick, rs;
        locked = lock_en && m_valid && req[m_id];
        if (arb_type[2]) begin
            m_valid = 0; m_id = 0; m_run = 0;
        end else if (locked && m_run < LIMIT) begin
            m_run++;
        end else begin
            cand = req;
            if (locked) cand[m_id] = 1'b0;
            rs = int'(m_lfsr[1:0]);
            if (rs >= N) rs = rs - N;
            case (arb_type[1:0])
                2'd0:    pick = first_from(cand, 0);
                2'd1:    pick = cand[prio_sel] ? int'(prio_sel) : first_from(cand, 0);
                2'd2:    pick = first_from(cand, (m_last + 1) % N);
                default: pick = first_from(cand, rs);
            endcase
            if (pick < 0 && locked) pick = m_id;
            if (pick >= 0) begin
                m_valid = 1; m_id = pick; m_run = 1;
            end else begin
                m_valid = 0; m_id = 0; m_run = 0;
            end
        end
        if (m_valid) m_last = m_id;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("gnt", 32'(gnt), m_valid ? (32'd1 << m_id) : 32'd0);
        check("gnt_id", 32'(gnt_id), 32'(m_id));
        check("gnt_valid", 32'(gnt_valid), 32'(m_valid));
        check("lfsr", 32'(dut.u_lfsr.value), 32'(m_lfsr));
    endtask

    task automatic do_reset();
        logic [15:0] seed;
        seed = LFSR_SEED;
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        m_valid = 0; m_id = 0; m_last = N - 1; m_run = 0;
        m_lfsr  = seed[7:0];
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Fixed-low
        arb_type = 3'b000; req = 4'b1010;
        tick(); check("m000_gnt", 32'(gnt), 32'b0010); check("m000_id", 32'(gnt_id), 32'd1);
        req = 4'b0000;
        tick(); check("m000_none", 32'(gnt), 32'd0); check("m000_nv", 32'(gnt_valid), 32'd0);
        arb_type = 3'b100; req = 4'b1111;
        tick(); check("disabled", 32'(gnt), 32'd0);

        // Round-robin from reset
        do_reset();
        arb_type = 3'b010; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp_rr [5];
            exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            tick(); check("rr_seq", 32'(gnt), 32'(exp_rr[i]));
        end

        // Programmable priority
        arb_type = 3'b001; prio_sel = 2'd2; req = 4'b0101;
        tick(); check("m001_prio", 32'(gnt), 32'b0100);
        req = 4'b0001;
        tick(); check("m001_low", 32'(gnt), 32'b0001);

        // Lock released when the holder's request drops
        do_reset();
        arb_type = 3'b010; lock_en = 1'b1; req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick(); check("lock_hold", 32'(gnt), 32'b0001);
        end
        req = 4'b0010;
        tick(); check("lock_release", 32'(gnt), 32'b0010);

        // Lock limit forces rotation away from the holder
        do_reset();
        arb_type = 3'b010; lock_en = 1'b1; req = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            tick(); check("lock_limit_hold", 32'(gnt), 32'b0001);
        end
        tick(); check("lock_limit_force", 32'(gnt), 32'b0010);
        req = 4'b0001;
        for (int i = 0; i < 40; i++) tick();
        check("lock_sole_req", 32'(gnt), 32'b0001);

        // Reset mid-lock
        do_reset();
        arb_type = 3'b010; lock_en = 1'b1; req = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick(); check("pre_rst_lock", 32'(gnt), 32'b1000);
        end
        do_reset();
        req = 4'b1001;
        tick(); check("post_rst_rr", 32'(gnt), 32'b0001);

        // Random mode fairness and repeatability
        do_reset();
        arb_type = 3'b011; lock_en = 1'b0; req = 4'b1111;
        for (int r = 0; r < 4; r++) cnt[r] = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            seq[i] = gnt;
            for (int r = 0; r < 4; r++) if (gnt[r]) cnt[r]++;
            check("rand_onehot", 32'($onehot(gnt)), 32'd1);
        end
        for (int r = 0; r < 4; r++) check("rand_fair", 32'(cnt[r] >= 150), 32'd1);
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            tick(); check("rand_repeat", 32'(gnt), 32'(seq[i]));
        end

        // Randomized mix of modes, requests and lock
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) arb_type = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) lock_en = ($urandom_range(0, 3) != 0);
            prio_sel = 2'($urandom);
            tick();
        end

        // Six-requester instance: prio_sel beyond range falls back to lowest
        arb_type = 3'b000; req = 4'b0000; lock_en = 1'b0;
        req6 = 6'b101100;
        begin
            logic [2:0] ps_tab [5];
            logic [5:0] g_tab  [5];
            ps_tab = '{3'd6, 3'd7, 3'd5, 3'd4, 3'd3};
            g_tab  = '{6'b000100, 6'b000100, 6'b100000, 6'b000100, 6'b001000};
            for (int i = 0; i < 5; i++) begin
                prio6 = ps_tab[i];
                tick();
                check("n6_gnt", 32'(gnt6), 32'(g_tab[i]));
                check("n6_valid", 32'(gv6), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
